// File: rtl/tlb_array_lru.sv
// Set-associative TLB array: ASID-tagged lookup and fill with per-set age LRU,
// plus a one-set-per-cycle flush walk that can be restricted to a single ASID.
module tlb_array_lru #(
  parameter  int unsigned NUM_SETS = 16,
  parameter  int unsigned NUM_WAYS = 4,
  parameter  int unsigned VPN_W    = 20,
  parameter  int unsigned PPN_W    = 20,
  parameter  int unsigned PERM_W   = 2,
  parameter  int unsigned ASID_W   = 8,
  localparam int unsigned SET_W    = $clog2(NUM_SETS),
  localparam int unsigned WAY_W    = $clog2(NUM_WAYS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              lk_req,
  input  logic [VPN_W-1:0]  lk_vpn,
  input  logic [ASID_W-1:0] lk_asid,
  output logic              lk_vld,
  output logic              lk_hit,
  output logic [WAY_W-1:0]  lk_way,
  output logic [PPN_W-1:0]  lk_ppn,
  output logic [PERM_W-1:0] lk_perms,
  input  logic              fill_req,
  input  logic [VPN_W-1:0]  fill_vpn,
  input  logic [ASID_W-1:0] fill_asid,
  input  logic [PPN_W-1:0]  fill_ppn,
  input  logic [PERM_W-1:0] fill_perms,
  output logic              fill_ack,
  output logic [WAY_W-1:0]  fill_way,
  input  logic              flush_req,
  input  logic              flush_asid_en,
  input  logic [ASID_W-1:0] flush_asid,
  output logic              busy
);

  localparam int unsigned CNT_W = SET_W + 1;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_FLUSH = 1'b1} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                fen_q, fen_d;
  logic [ASID_W-1:0]   fasid_q, fasid_d;

  logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
  logic [NUM_WAYS-1:0] valid_d [NUM_SETS];
  logic [WAY_W-1:0]    age_q   [NUM_SETS][NUM_WAYS];
  logic [WAY_W-1:0]    age_d   [NUM_SETS][NUM_WAYS];
  logic [VPN_W-1:0]    vpn_q   [NUM_SETS][NUM_WAYS];
  logic [ASID_W-1:0]   asid_q  [NUM_SETS][NUM_WAYS];
  logic [PPN_W-1:0]    ppn_q   [NUM_SETS][NUM_WAYS];
  logic [PERM_W-1:0]   perms_q [NUM_SETS][NUM_WAYS];

  logic                lk_vld_q, lk_vld_d;
  logic                lk_hit_q, lk_hit_d;
  logic [WAY_W-1:0]    lk_way_q, lk_way_d;
  logic [PPN_W-1:0]    lk_ppn_q, lk_ppn_d;
  logic [PERM_W-1:0]   lk_perms_q, lk_perms_d;
  logic                fill_ack_q, fill_ack_d;
  logic [WAY_W-1:0]    fill_way_q, fill_way_d;
  logic                busy_q, busy_d;

  logic [SET_W-1:0]    lk_set, fill_set, flush_set;
  logic                accept, lk_acc, fill_acc;
  logic                lk_match, fill_match, inv_found;
  logic [WAY_W-1:0]    lk_hway, fill_hway, inv_way, old_way, victim;
  logic [WAY_W-1:0]    lk_age, fill_age;

  // Next-state: lookup, fill victim selection, age touches and the flush walk
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    fen_d      = fen_q;
    fasid_d    = fasid_q;
    valid_d    = valid_q;
    age_d      = age_q;
    lk_vld_d   = 1'b0;
    lk_hit_d   = 1'b0;
    lk_way_d   = '0;
    lk_ppn_d   = '0;
    lk_perms_d = '0;
    fill_ack_d = 1'b0;
    fill_way_d = '0;
    lk_match   = 1'b0;
    fill_match = 1'b0;
    inv_found  = 1'b0;
    lk_hway    = '0;
    fill_hway  = '0;
    inv_way    = '0;
    old_way    = '0;
    lk_set     = lk_vpn[SET_W-1:0];
    fill_set   = fill_vpn[SET_W-1:0];
    flush_set  = cnt_q[SET_W-1:0];
    accept     = (state_q == ST_IDLE) && !flush_req;
    lk_acc     = accept && lk_req;
    fill_acc   = accept && fill_req;

    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[lk_set][w] && vpn_q[lk_set][w] == lk_vpn && asid_q[lk_set][w] == lk_asid) begin
        lk_match = 1'b1;
        lk_hway  = WAY_W'(w);
      end
      if (valid_q[fill_set][w] && vpn_q[fill_set][w] == fill_vpn &&
          asid_q[fill_set][w] == fill_asid) begin
        fill_match = 1'b1;
        fill_hway  = WAY_W'(w);
      end
      if (!valid_q[fill_set][w] && !inv_found) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
      if (age_q[fill_set][w] == WAY_W'(NUM_WAYS - 1)) begin
        old_way = WAY_W'(w);
      end
    end
    victim   = fill_match ? fill_hway : (inv_found ? inv_way : old_way);
    lk_age   = age_q[lk_set][lk_hway];
    fill_age = age_q[fill_set][victim];

    if (lk_acc) begin
      lk_vld_d = 1'b1;
      if (lk_match) begin
        lk_hit_d   = 1'b1;
        lk_way_d   = lk_hway;
        lk_ppn_d   = ppn_q[lk_set][lk_hway];
        lk_perms_d = perms_q[lk_set][lk_hway];
        for (int w = 0; w < NUM_WAYS; w++) begin
          if (WAY_W'(w) == lk_hway) begin
            age_d[lk_set][w] = '0;
          end else if (age_q[lk_set][w] < lk_age) begin
            age_d[lk_set][w] = age_q[lk_set][w] + WAY_W'(1);
          end
        end
      end
    end

    // The fill rewrites its whole age row, so it overrides a same-set lookup touch
    if (fill_acc) begin
      fill_ack_d = 1'b1;
      fill_way_d = victim;
      valid_d[fill_set][victim] = 1'b1;
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (WAY_W'(w) == victim) begin
          age_d[fill_set][w] = '0;
        end else if (age_q[fill_set][w] < fill_age) begin
          age_d[fill_set][w] = age_q[fill_set][w] + WAY_W'(1);
        end else begin
          age_d[fill_set][w] = age_q[fill_set][w];
        end
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (flush_req) begin
          state_d = ST_FLUSH;
          cnt_d   = '0;
          fen_d   = flush_asid_en;
          fasid_d = flush_asid;
        end
      end
      ST_FLUSH: begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          if (!fen_q || asid_q[flush_set][w] == fasid_q) begin
            valid_d[flush_set][w] = 1'b0;
          end
        end
        if (cnt_q == CNT_W'(NUM_SETS - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
    busy_d = (state_d == ST_FLUSH);
  end

  // Control, valid/age state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      fen_q      <= 1'b0;
      fasid_q    <= '0;
      lk_vld_q   <= 1'b0;
      lk_hit_q   <= 1'b0;
      lk_way_q   <= '0;
      lk_ppn_q   <= '0;
      lk_perms_q <= '0;
      fill_ack_q <= 1'b0;
      fill_way_q <= '0;
      busy_q     <= 1'b0;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
          age_q[s][w] <= WAY_W'(w);
        end
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fen_q      <= fen_d;
      fasid_q    <= fasid_d;
      lk_vld_q   <= lk_vld_d;
      lk_hit_q   <= lk_hit_d;
      lk_way_q   <= lk_way_d;
      lk_ppn_q   <= lk_ppn_d;
      lk_perms_q <= lk_perms_d;
      fill_ack_q <= fill_ack_d;
      fill_way_q <= fill_way_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      age_q      <= age_d;
    end
  end

  // Entry payload needs no reset; valid bits gate every use of it
  always_ff @(posedge clk) begin
    if (fill_acc) begin
      vpn_q[fill_set][victim]   <= fill_vpn;
      asid_q[fill_set][victim]  <= fill_asid;
      ppn_q[fill_set][victim]   <= fill_ppn;
      perms_q[fill_set][victim] <= fill_perms;
    end
  end

  assign lk_vld   = lk_vld_q;
  assign lk_hit   = lk_hit_q;
  assign lk_way   = lk_way_q;
  assign lk_ppn   = lk_ppn_q;
  assign lk_perms = lk_perms_q;
  assign fill_ack = fill_ack_q;
  assign fill_way = fill_way_q;
  assign busy     = busy_q;

endmodule

// File: doc/tlb_array_lru.md
TLB_ARRAY_LRU -- requirements
Module: tlb_array_lru

Interface
REQ-001 Parameter NUM_SETS, 16, number of sets; power of two, >=2.
REQ-002 Parameter NUM_WAYS, 4, associativity; power of two, >=2.
REQ-003 Parameter VPN_W, 20, virtual page number width.
REQ-004 Parameter PPN_W, 20, physical page number width.
REQ-005 Parameter PERM_W, 2, permission field width.
REQ-006 Parameter ASID_W, 8, address-space ID width.
REQ-007 Derived widths: SET_W = clog2(NUM_SETS); WAY_W = clog2(NUM_WAYS); these SHALL NOT be overridable.
REQ-008 clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-009 rst_n  in  1  asynchronous, active-low reset.
REQ-010 lk_req  in  1  lookup request.
REQ-011 lk_vpn  in  VPN_W  lookup VPN; set index = lk_vpn[SET_W-1:0].
REQ-012 lk_asid  in  ASID_W  lookup ASID.
REQ-013 lk_vld  out  1  lookup result valid, one-cycle pulse.
REQ-014 lk_hit  out  1  lookup hit.
REQ-015 lk_way  out  WAY_W  hitting way.
REQ-016 lk_ppn  out  PPN_W  hitting PPN.
REQ-017 lk_perms  out  PERM_W  hitting permissions.
REQ-018 fill_req  in  1  fill request.
REQ-019 fill_vpn / fill_asid / fill_ppn / fill_perms  in  VPN_W / ASID_W / PPN_W / PERM_W  fill entry fields.
REQ-020 fill_ack  out  1  fill done, one-cycle pulse.
REQ-021 fill_way  out  WAY_W  way written by the acknowledged fill.
REQ-022 flush_req  in  1  start flush.
REQ-023 flush_asid_en  in  1  when 1, flush only entries with ASID == flush_asid.
REQ-024 flush_asid  in  ASID_W  ASID selector, sampled with flush_req.
REQ-025 busy  out  1  flush in progress.

Function
REQ-026 Per entry: valid, VPN, ASID, PPN, perms, age[WAY_W]; within each set the ages SHALL always form a permutation of 0..NUM_WAYS-1.
REQ-027 Hit: valid && VPN == lk_vpn && ASID == lk_asid; at most one way SHALL match.
REQ-028 Lookup latency 1: lk_req accepted in cycle N -> lk_vld=1 in N+1 with registered hit/way/ppn/perms; on a miss lk_way, lk_ppn and lk_perms = 0.
REQ-029 Fill latency 1: fill_req accepted in N -> entry written at the N edge; fill_ack=1 and fill_way valid in N+1; a lookup in N+1 sees the new entry.
REQ-030 Fill victim: an existing VPN+ASID match is overwritten; otherwise the lowest-index invalid way; otherwise the way with age NUM_WAYS-1.
REQ-031 Age touch of way w with old age a, on hit or fill: age[w] <= 0; every way with age < a increments; all other ages hold.
REQ-032 Same-cycle lookup and fill: both accepted; the lookup sees pre-fill contents; if both target the same set, only the fill touches ages.
REQ-033 FSM states IDLE and FLUSH. IDLE -> FLUSH on flush_req; FLUSH walks sets 0..NUM_SETS-1, one set per cycle; FLUSH -> IDLE after set NUM_SETS-1.
REQ-034 busy=1 in every FLUSH cycle, for exactly NUM_SETS cycles beginning the cycle after flush_req.
REQ-035 Flushing a set clears valid on matching entries (all entries when flush_asid_en=0); ages SHALL be preserved.
REQ-036 While busy=1, or in the flush_req cycle, lk_req, fill_req and flush_req SHALL be ignored: no lk_vld, no fill_ack, no write.
REQ-037 Set-index wrap: the flush counter is SET_W+1 bits wide; termination SHALL NOT rely on counter overflow.

Reset
REQ-038 Asserting rst_n=0 SHALL immediately clear all valids, set age[w]=w in every set, force IDLE, and drive lk_vld, lk_hit, lk_way, lk_ppn, lk_perms, fill_ack, fill_way and busy to 0.
REQ-039 Reset during FLUSH SHALL abort the walk with no partial state visible after release.
REQ-040 The first request is accepted on the first rising edge with rst_n=1.

Verification
REQ-041 After reset, lookup VPN 0x00012, ASID 3 -> in N+1: lk_vld=1, lk_hit=0, lk_ppn=0.
REQ-042 Fill VPN 0x00012, ASID 3, PPN 0xABCDE, perms 2'b10 -> fill_ack with fill_way=0; next-cycle lookup -> hit, way 0, PPN 0xABCDE, perms 2'b10; the same lookup with ASID 4 -> miss.
REQ-043 Five fills with distinct VPNs to set 2 -> ways 0,1,2,3, then the fifth evicts way 0; after a hit on way 1 and a sixth fill -> way 2 is evicted.
REQ-044 flush_req with flush_asid_en=1, flush_asid=3, and entries of ASIDs 3 and 5 present -> busy high for 16 cycles; lk_req/fill_req ignored meanwhile; afterwards ASID-3 entries miss and ASID-5 entries hit.
REQ-045 Same-cycle fill and lookup of the same VPN -> lookup misses; a repeat lookup hits; the ages of that set match the fill-only touch.
REQ-046 rst_n pulsed low at flush cycle 5 -> busy=0 immediately; all lookups miss after release; a new flush takes the full 16 cycles.
